bus_xfer_sequencer: RTL and testbench

- Controller end of the register load/enable-out interface on the shared 8-bit W-bus.
- Accepts a transfer request (source register, destination register). Drives the source's tri-state enable-out and then the destination's load strobe in a fixed, contention-free sequence.
- Snapshots the transferred byte and reports done or error.
- Sits between the control sequencer and the bank of bus-attached registers (TMP, B, C, ACC, OUT ports, etc.).

---
 rtl/bus_xfer_sequencer_if.sv | 27 ++
 rtl/bus_xfer_sequencer.sv | 127 ++++++++++++
 tb/tb_bus_xfer_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bus_xfer_sequencer_if.sv
// W-bus transfer interface between a requester and the bus_xfer_sequencer.
// The master drives request, indices and the observed bus byte; the slave drives all status and strobes.
interface bus_xfer_sequencer_if #(
    parameter int NUM_REG = 8,
    parameter int ID_W    = 3
);
    logic               inReq;
    logic [ID_W-1:0]    inSrc;
    logic [ID_W-1:0]    inDst;
    logic [7:0]         inBusData;
    logic               outReady;
    logic [NUM_REG-1:0] outEnableOut;
    logic [NUM_REG-1:0] outLoad;
    logic               outDone;
    logic               outError;
    logic [7:0]         outLastData;

    modport master (
        output inReq, inSrc, inDst, inBusData,
        input  outReady, outEnableOut, outLoad, outDone, outError, outLastData
    );

    modport slave (
        input  inReq, inSrc, inDst, inBusData,
        output outReady, outEnableOut, outLoad, outDone, outError, outLastData
    );
endinterface

// File: rtl/bus_xfer_sequencer.sv
// Sequences one W-bus register transfer: enable-out source, then load destination; done after SETTLE_CYCLES+2 edges.
// Accepts a request only while outReady is high; requests seen while busy are dropped, the requester must hold.
module bus_xfer_sequencer #(
    parameter int NUM_REG       = 8,
    parameter int ID_W          = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 inCLK,
    input  logic                 inCLR_n,
    bus_xfer_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, DRIVE, LOAD, DONE, ERR} state_t;

    // One extra bit so NUM_REG == 2**ID_W does not wrap to zero in the range check.
    localparam logic [ID_W:0] NUM_REG_W = (ID_W+1)'(NUM_REG);

    state_t             state, state_n;
    logic [ID_W-1:0]    src_q, src_n, dst_q, dst_n;
    logic [3:0]         cnt_q, cnt_n;
    logic [NUM_REG-1:0] en_q, en_n, ld_q, ld_n;
    logic               ready_q, ready_n, done_q, done_n, err_q, err_n;
    logic [7:0]         last_q, last_n;
    logic               req_bad;

    function automatic logic [NUM_REG-1:0] onehot(input logic [ID_W-1:0] idx);
        logic [NUM_REG-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            v[i] = (idx == ID_W'(i));
        end
        return v;
    endfunction

    assign req_bad = (bus.inSrc == bus.inDst)
                   || ({1'b0, bus.inSrc} >= NUM_REG_W)
                   || ({1'b0, bus.inDst} >= NUM_REG_W);

    always_ff @(posedge inCLK) begin
        if (!inCLR_n) begin
            state   <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            en_q    <= '0;
            ld_q    <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 8'h00;
        end else begin
            state   <= state_n;
            src_q   <= src_n;
            dst_q   <= dst_n;
            cnt_q   <= cnt_n;
            en_q    <= en_n;
            ld_q    <= ld_n;
            ready_q <= ready_n;
            done_q  <= done_n;
            err_q   <= err_n;
            last_q  <= last_n;
        end
    end

    // Every output is a flop loaded from its next-state value, so none depends combinationally on inputs.
    always_comb begin
        state_n = state;
        src_n   = src_q;
        dst_n   = dst_q;
        cnt_n   = cnt_q;
        en_n    = en_q;
        ld_n    = ld_q;
        ready_n = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        last_n  = last_q;
        case (state)
            IDLE: begin
                ready_n = 1'b1;
                if (bus.inReq) begin
                    src_n   = bus.inSrc;
                    dst_n   = bus.inDst;
                    ready_n = 1'b0;
                    if (req_bad) begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end else begin
                        state_n = DRIVE;
                        en_n    = onehot(bus.inSrc);
                        cnt_n   = 4'(SETTLE_CYCLES - 1);
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_n = LOAD;
                    ld_n    = onehot(dst_q);
                end else begin
                    cnt_n = cnt_q - 4'd1;
                end
            end
            LOAD: begin
                last_n  = bus.inBusData;
                en_n    = '0;
                ld_n    = '0;
                done_n  = 1'b1;
                state_n = DONE;
            end
            DONE, ERR: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
            default: begin
                state_n = IDLE;
                ready_n = 1'b1;
                en_n    = '0;
                ld_n    = '0;
            end
        endcase
    end

    assign bus.outReady     = ready_q;
    assign bus.outEnableOut = en_q;
    assign bus.outLoad      = ld_q;
    assign bus.outDone      = done_q;
    assign bus.outError     = err_q;
    assign bus.outLastData  = last_q;
endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Directed bench: table of single transfers on the SETTLE=1 instance, plus hand-written multi-cycle sequences.
module tb_bus_xfer_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    bus_xfer_sequencer_if #(.NUM_REG(8), .ID_W(3)) b0 ();
    bus_xfer_sequencer_if #(.NUM_REG(8), .ID_W(3)) b1 ();
    bus_xfer_sequencer_if #(.NUM_REG(6), .ID_W(3)) b2 ();

    bus_xfer_sequencer #(.NUM_REG(8), .ID_W(3), .SETTLE_CYCLES(1)) dut0 (
        .inCLK(clk), .inCLR_n(rst_n), .bus(b0.slave));
    bus_xfer_sequencer #(.NUM_REG(8), .ID_W(3), .SETTLE_CYCLES(4)) dut1 (
        .inCLK(clk), .inCLR_n(rst_n), .bus(b1.slave));
    bus_xfer_sequencer #(.NUM_REG(6), .ID_W(3), .SETTLE_CYCLES(1)) dut2 (
        .inCLK(clk), .inCLR_n(rst_n), .bus(b2.slave));

    typedef struct {
        logic [2:0] src;
        logic [2:0] dst;
        logic [7:0] data;
        logic       err;
        logic [7:0] en;
        logic [7:0] ld;
        logic [7:0] last;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string p;
        p = $sformatf("vec%0d", idx);
        @(negedge clk);
        chk({p, "_ready_pre"}, 32'(b0.outReady), 32'd1);
        b0.inReq = 1'b1; b0.inSrc = v.src; b0.inDst = v.dst; b0.inBusData = v.data;
        @(negedge clk);
        b0.inReq = 1'b0;
        if (v.err) begin
            chk({p, "_err"},  32'(b0.outError), 32'd1);
            chk({p, "_en"},   32'(b0.outEnableOut), 32'd0);
            chk({p, "_ld"},   32'(b0.outLoad), 32'd0);
            chk({p, "_busy"}, 32'(b0.outReady), 32'd0);
            @(negedge clk);
            chk({p, "_err_end"}, 32'(b0.outError), 32'd0);
            chk({p, "_ready"},   32'(b0.outReady), 32'd1);
            chk({p, "_done"},    32'(b0.outDone), 32'd0);
            chk({p, "_last"},    32'(b0.outLastData), 32'(v.last));
        end else begin
            chk({p, "_en_c1"},   32'(b0.outEnableOut), 32'(v.en));
            chk({p, "_ld_c1"},   32'(b0.outLoad), 32'd0);
            chk({p, "_done_c1"}, 32'(b0.outDone), 32'd0);
            @(negedge clk);
            chk({p, "_en_c2"}, 32'(b0.outEnableOut), 32'(v.en));
            chk({p, "_ld_c2"}, 32'(b0.outLoad), 32'(v.ld));
            @(negedge clk);
            chk({p, "_en_c3"},   32'(b0.outEnableOut), 32'd0);
            chk({p, "_ld_c3"},   32'(b0.outLoad), 32'd0);
            chk({p, "_done_c3"}, 32'(b0.outDone), 32'd1);
            chk({p, "_last"},    32'(b0.outLastData), 32'(v.last));
            @(negedge clk);
            chk({p, "_ready"},   32'(b0.outReady), 32'd1);
            chk({p, "_done_c4"}, 32'(b0.outDone), 32'd0);
        end
    endtask

    task automatic run_dut2(input string p, input logic [2:0] s, input logic [2:0] d,
                            input logic [7:0] data, input logic err,
                            input logic [5:0] en, input logic [5:0] ld);
        @(negedge clk);
        b2.inReq = 1'b1; b2.inSrc = s; b2.inDst = d; b2.inBusData = data;
        @(negedge clk);
        b2.inReq = 1'b0;
        chk({p, "_err"}, 32'(b2.outError), 32'(err));
        chk({p, "_en1"}, 32'(b2.outEnableOut), 32'(en));
        @(negedge clk);
        chk({p, "_ld2"}, 32'(b2.outLoad), 32'(ld));
        if (!err) begin
            @(negedge clk);
            chk({p, "_done"}, 32'(b2.outDone), 32'd1);
            chk({p, "_last"}, 32'(b2.outLastData), 32'(data));
            @(negedge clk);
        end
        chk({p, "_ready"}, 32'(b2.outReady), 32'd1);
    endtask

    initial begin
        int en_cnt, ld_cnt, ld_at, done_at, stray;
        int first_a, first_b, dones, multi;

        vecs[0] = '{3'd2, 3'd5, 8'hA7, 1'b0, 8'h04, 8'h20, 8'hA7};
        vecs[1] = '{3'd3, 3'd3, 8'h55, 1'b1, 8'h00, 8'h00, 8'hA7};
        vecs[2] = '{3'd0, 3'd7, 8'h3C, 1'b0, 8'h01, 8'h80, 8'h3C};
        vecs[3] = '{3'd7, 3'd0, 8'hC3, 1'b0, 8'h80, 8'h01, 8'hC3};
        vecs[4] = '{3'd6, 3'd6, 8'hFF, 1'b1, 8'h00, 8'h00, 8'hC3};
        vecs[5] = '{3'd1, 3'd4, 8'h5A, 1'b0, 8'h02, 8'h10, 8'h5A};

        b0.inReq = 1'b0; b0.inSrc = '0; b0.inDst = '0; b0.inBusData = '0;
        b1.inReq = 1'b0; b1.inSrc = '0; b1.inDst = '0; b1.inBusData = '0;
        b2.inReq = 1'b0; b2.inSrc = '0; b2.inDst = '0; b2.inBusData = '0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(b0.outReady), 32'd1);
        chk("rst_en",    32'(b0.outEnableOut), 32'd0);
        chk("rst_ld",    32'(b0.outLoad), 32'd0);
        chk("rst_done",  32'(b0.outDone), 32'd0);
        chk("rst_err",   32'(b0.outError), 32'd0);
        chk("rst_last",  32'(b0.outLastData), 32'd0);
        chk("rst_ready1", 32'(b1.outReady), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // SETTLE_CYCLES=4: enable for 5 cycles, load in the 5th, done in the 6th.
        @(negedge clk);
        b1.inReq = 1'b1; b1.inSrc = 3'd0; b1.inDst = 3'd7; b1.inBusData = 8'h99;
        en_cnt = 0; ld_cnt = 0; ld_at = 0; done_at = 0; stray = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) b1.inReq = 1'b0;
            if (b1.outEnableOut == 8'h01) en_cnt++;
            else if (b1.outEnableOut != 8'h00) stray++;
            if (b1.outLoad == 8'h80) begin ld_cnt++; ld_at = k; end
            else if (b1.outLoad != 8'h00) stray++;
            if (b1.outDone) done_at = k;
        end
        chk("settle_en_cycles", 32'(en_cnt), 32'd5);
        chk("settle_ld_cycles", 32'(ld_cnt), 32'd1);
        chk("settle_ld_at",     32'(ld_at), 32'd5);
        chk("settle_done_at",   32'(done_at), 32'd6);
        chk("settle_stray",     32'(stray), 32'd0);
        chk("settle_last",      32'(b1.outLastData), 32'h99);

        // Second request raised during DRIVE and held until it is taken.
        @(negedge clk);
        b0.inReq = 1'b1; b0.inSrc = 3'd2; b0.inDst = 3'd5; b0.inBusData = 8'h11;
        first_a = 0; first_b = 0; dones = 0; multi = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin b0.inSrc = 3'd1; b0.inDst = 3'd4; end
            if (b0.outEnableOut[2] && first_a == 0) first_a = k;
            if (b0.outEnableOut[1] && first_b == 0) begin
                first_b = k;
                b0.inReq = 1'b0;
                b0.inBusData = 8'h22;
            end
            if ($countones(b0.outEnableOut) > 1 || $countones(b0.outLoad) > 1) multi++;
            if (b0.outDone) dones++;
        end
        b0.inReq = 1'b0;
        chk("busy_first_a", 32'(first_a), 32'd1);
        chk("busy_gap",     32'(first_b - first_a), 32'd4);
        chk("busy_dones",   32'(dones), 32'd2);
        chk("busy_onehot",  32'(multi), 32'd0);
        chk("busy_last",    32'(b0.outLastData), 32'h22);

        // Reset asserted at the edge that would enter LOAD.
        @(negedge clk);
        b0.inReq = 1'b1; b0.inSrc = 3'd2; b0.inDst = 3'd5; b0.inBusData = 8'h77;
        @(negedge clk);
        b0.inReq = 1'b0;
        chk("midrst_drive_en", 32'(b0.outEnableOut), 32'h04);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_en",    32'(b0.outEnableOut), 32'd0);
        chk("midrst_ld",    32'(b0.outLoad), 32'd0);
        chk("midrst_ready", 32'(b0.outReady), 32'd1);
        chk("midrst_done",  32'(b0.outDone), 32'd0);
        chk("midrst_last",  32'(b0.outLastData), 32'd0);
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (b0.outLoad != 8'h00 || b0.outDone || b0.outEnableOut != 8'h00) stray++;
        end
        chk("midrst_quiet", 32'(stray), 32'd0);

        // NUM_REG=6: indices 6 and 7 are out of range.
        run_dut2("oor_dst6", 3'd0, 3'd6, 8'h12, 1'b1, 6'h00, 6'h00);
        run_dut2("oor_src7", 3'd7, 3'd1, 8'h34, 1'b1, 6'h00, 6'h00);
        chk("oor_last", 32'(b2.outLastData), 32'd0);
        run_dut2("n6_valid", 3'd5, 3'd0, 8'h3E, 1'b0, 6'h20, 6'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
